// File: rtl/miner_job_master.sv
// Avalon-MM master that runs one SHA3 miner job: loads the registers, starts the miner, collects the solution.
// Latency: first write the cycle after accept, 19 write cycles to start, result 9 cycles after the IRQ (4 reads + stop).
// Backpressure: job_ready only in IDLE; the result is held in RESULT until res_ready; no waitrequest on the slave side.
module miner_job_master #(
  parameter int TIMEOUT_W = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_header,
  input  logic [255:0] job_difficulty,
  input  logic [63:0]  job_start_nonce,
  input  logic [7:0]   job_pad_first,
  input  logic [7:0]   job_pad_last,
  input  logic         job_test,
  input  logic         abort,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_irq,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [63:0]  res_nonce,
  output logic [31:0]  res_status,
  output logic         res_timeout,
  output logic         busy
);

  localparam logic                 TO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [4:0]           A_SOL0  = 5'd0;
  localparam logic [4:0]           A_SOL1  = 5'd1;
  localparam logic [4:0]           A_STAT  = 5'd2;
  localparam logic [4:0]           A_HDR   = 5'd4;
  localparam logic [4:0]           A_CTL   = 5'd22;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT_IRQ, S_RD_CTL,
    S_RD_SOL0, S_RD_SOL1, S_RD_STAT, S_STOP, S_RESULT
  } state_t;

  state_t               state, state_nxt;
  logic                 rd_cap, rd_cap_nxt;   // 0: ISSUE phase, 1: CAPTURE phase
  logic [4:0]           load_idx, load_idx_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 job_ready_q;

  logic [255:0]         header_q, difficulty_q;
  logic [63:0]          start_nonce_q;
  logic [7:0]           pad_first_q, pad_last_q;
  logic                 test_q;
  logic                 drop_q, timeout_q;
  logic [63:0]          nonce_q;
  logic [31:0]          status_q;

  logic                 accept, drop_set, timeout_set;
  logic                 rd_active;
  logic [4:0]           rd_addr;
  state_t               rd_next;

  // The 18 load words in bus order: header, difficulty, nonce, each most-significant word first.
  logic [575:0] load_vec;
  logic [31:0]  load_word;
  assign load_vec  = {header_q, difficulty_q, start_nonce_q};
  assign load_word = load_vec[32*(17 - int'(load_idx)) +: 32];

  // State register; job_ready is registered so it rises on the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_cap      <= 1'b0;
      load_idx    <= '0;
      job_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_cap      <= rd_cap_nxt;
      load_idx    <= load_idx_nxt;
      job_ready_q <= (state_nxt == S_IDLE);
    end
  end

  // Wait-for-solution counter: zero on the first WAIT_IRQ cycle, counts while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= '0;
    else if (state != S_WAIT_IRQ) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end

  // Job latch, end-of-job flags and read-back capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header_q      <= '0;
      difficulty_q  <= '0;
      start_nonce_q <= '0;
      pad_first_q   <= '0;
      pad_last_q    <= '0;
      test_q        <= 1'b0;
      drop_q        <= 1'b0;
      timeout_q     <= 1'b0;
      nonce_q       <= '0;
      status_q      <= '0;
    end else begin
      if (accept) begin
        header_q      <= job_header;
        difficulty_q  <= job_difficulty;
        start_nonce_q <= job_start_nonce;
        pad_first_q   <= job_pad_first;
        pad_last_q    <= job_pad_last;
        test_q        <= job_test;
        drop_q        <= 1'b0;
        timeout_q     <= 1'b0;
        nonce_q       <= '0;
        status_q      <= '0;
      end
      if (drop_set)    drop_q    <= 1'b1;
      if (timeout_set) timeout_q <= 1'b1;
      if (rd_cap) begin
        case (state)
          S_RD_SOL0: nonce_q[31:0]  <= avm_readdata;
          S_RD_SOL1: nonce_q[63:32] <= avm_readdata;
          S_RD_STAT: status_q       <= avm_readdata;
          default:   ;
        endcase
      end
    end
  end

  // Next state and bus strobes; abort always lets the current single-cycle access finish first.
  always_comb begin
    state_nxt     = state;
    rd_cap_nxt    = rd_cap;
    load_idx_nxt  = load_idx;
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    accept        = 1'b0;
    drop_set      = 1'b0;
    timeout_set   = 1'b0;
    rd_active     = 1'b0;
    rd_addr       = '0;
    rd_next       = S_IDLE;
    case (state)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          accept       = 1'b1;
          load_idx_nxt = '0;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        avm_write     = 1'b1;
        avm_address   = A_HDR + load_idx;
        avm_writedata = load_word;
        if (abort) begin
          drop_set  = 1'b1;
          state_nxt = S_STOP;
        end else if (load_idx == 5'd17) begin
          state_nxt = S_RUN;
        end else begin
          load_idx_nxt = load_idx + 5'd1;
        end
      end
      S_RUN: begin
        avm_write     = 1'b1;
        avm_address   = A_CTL;
        avm_writedata = {pad_first_q, pad_last_q, 13'b0, 1'b0, test_q, 1'b1};
        drop_set      = abort;
        state_nxt     = abort ? S_STOP : S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (abort) begin
          drop_set  = 1'b1;
          state_nxt = S_STOP;
        end else if (avm_irq) begin
          rd_cap_nxt = 1'b0;
          state_nxt  = S_RD_CTL;
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          timeout_set = 1'b1;
          state_nxt   = S_STOP;
        end
      end
      S_RD_CTL: begin
        rd_active = 1'b1;
        rd_addr   = A_CTL;
        rd_next   = S_RD_SOL0;
      end
      S_RD_SOL0: begin
        rd_active = 1'b1;
        rd_addr   = A_SOL0;
        rd_next   = S_RD_SOL1;
      end
      S_RD_SOL1: begin
        rd_active = 1'b1;
        rd_addr   = A_SOL1;
        rd_next   = S_RD_STAT;
      end
      S_RD_STAT: begin
        rd_active = 1'b1;
        rd_addr   = A_STAT;
        rd_next   = S_STOP;
      end
      S_STOP: begin
        avm_write     = 1'b1;
        avm_address   = A_CTL;
        avm_writedata = {pad_first_q, pad_last_q, 16'b0};
        state_nxt     = drop_q ? S_IDLE : S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Shared two-phase read sequencing for the RD_* states.
    if (rd_active) begin
      if (!rd_cap) begin
        avm_read    = 1'b1;
        avm_address = rd_addr;
        rd_cap_nxt  = 1'b1;
      end else begin
        rd_cap_nxt = 1'b0;
        state_nxt  = rd_next;
      end
      if (abort) begin
        drop_set   = 1'b1;
        rd_cap_nxt = 1'b0;
        state_nxt  = S_STOP;
      end
    end
  end

  assign job_ready   = job_ready_q;
  assign res_valid   = (state == S_RESULT);
  assign res_nonce   = nonce_q;
  assign res_status  = status_q;
  assign res_timeout = timeout_q;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_miner_job_master.sv
module tb_miner_job_master;

  localparam int TO = 120;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid, job_ready;
  logic [255:0] job_header, job_difficulty;
  logic [63:0]  job_start_nonce;
  logic [7:0]   job_pad_first, job_pad_last;
  logic         job_test, abort;
  logic [4:0]   avm_address;
  logic         avm_read, avm_write;
  logic [31:0]  avm_writedata, avm_readdata;
  logic         avm_irq;
  logic         res_valid, res_ready;
  logic [63:0]  res_nonce;
  logic [31:0]  res_status;
  logic         res_timeout, busy;

  miner_job_master #(.TIMEOUT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_difficulty(job_difficulty),
    .job_start_nonce(job_start_nonce),
    .job_pad_first(job_pad_first), .job_pad_last(job_pad_last),
    .job_test(job_test), .abort(abort),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_irq(avm_irq),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_status(res_status),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [31:0] data;
    int         c;
  } acc_t;

  typedef struct {
    logic [255:0] header;
    logic [255:0] diff;
    logic [63:0]  nonce;
    logic [7:0]   pf;
    logic [7:0]   pl;
    logic         test;
    int           irq_d;   // WAIT_IRQ cycle index at which the slave raises irq; -1 = never
    logic [63:0]  sol;
    logic [31:0]  stat;
    int           rdy_d;   // res_valid cycles before res_ready is given
    logic [63:0]  e_nonce;
    logic [31:0]  e_status;
    logic         e_to;
    logic [31:0]  e_run;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int both_err = 0;
  acc_t log_q[$];
  acc_t exp_q[$];
  logic [63:0] sol_v;
  logic [31:0] stat_v;
  logic [31:0] ctl_reg;
  vec_t tbl[6];

  // Bus monitor plus a minimal slave: records every access and answers reads one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read && avm_write) both_err <= both_err + 1;
    if (avm_read || avm_write) log_q.push_back('{avm_write, avm_address, avm_writedata, cyc});
    if (avm_write && avm_address == 5'd22) ctl_reg <= avm_writedata;
    if (avm_read) begin
      case (avm_address)
        5'd0:    avm_readdata <= sol_v[31:0];
        5'd1:    avm_readdata <= sol_v[63:32];
        5'd2:    avm_readdata <= stat_v;
        5'd22:   avm_readdata <= ctl_reg;
        default: avm_readdata <= 32'h0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [255:0] h, input logic [255:0] d, input logic [63:0] n,
                              input logic [7:0] pf, input logic [7:0] pl, input logic t,
                              input int irq_d, input logic [63:0] sol, input logic [31:0] stat,
                              input int rdy_d, input logic [63:0] e_nonce, input logic [31:0] e_status,
                              input logic e_to, input logic [31:0] e_run);
    vec_t v;
    v.header = h; v.diff = d; v.nonce = n; v.pf = pf; v.pl = pl; v.test = t;
    v.irq_d = irq_d; v.sol = sol; v.stat = stat; v.rdy_d = rdy_d;
    v.e_nonce = e_nonce; v.e_status = e_status; v.e_to = e_to; v.e_run = e_run;
    return v;
  endfunction

  // Reference outcome of a job from the slave's behaviour alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r          = v;
    r.e_to     = (v.irq_d < 0) || (v.irq_d >= TO);
    r.e_nonce  = r.e_to ? 64'd0 : v.sol;
    r.e_status = r.e_to ? 32'd0 : v.stat;
    r.e_run    = {v.pf, v.pl, 16'h0} | (v.test ? 32'd3 : 32'd1);
    return r;
  endfunction

  // Expected bus trace for a complete (non-aborted) job.
  task automatic build_exp(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, 5'(4 + i), 32'(v.header >> (224 - 32 * i)), 0});
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b1, 5'(12 + i), 32'(v.diff >> (224 - 32 * i)), 0});
    exp_q.push_back('{1'b1, 5'd20, v.nonce[63:32], 0});
    exp_q.push_back('{1'b1, 5'd21, v.nonce[31:0], 0});
    exp_q.push_back('{1'b1, 5'd22, v.e_run, 0});
    if (!v.e_to) begin
      exp_q.push_back('{1'b0, 5'd22, 32'h0, 0});
      exp_q.push_back('{1'b0, 5'd0, 32'h0, 0});
      exp_q.push_back('{1'b0, 5'd1, 32'h0, 0});
      exp_q.push_back('{1'b0, 5'd2, 32'h0, 0});
    end
    exp_q.push_back('{1'b1, 5'd22, {v.pf, v.pl, 16'h0}, 0});
  endtask

  task automatic accept_job(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " job_ready idle"}, job_ready, 1);
    sol_v = v.sol; stat_v = v.stat;
    job_valid = 1'b1; job_header = v.header; job_difficulty = v.diff; job_start_nonce = v.nonce;
    job_pad_first = v.pf; job_pad_last = v.pl; job_test = v.test;
    @(negedge clk);
    job_valid = 1'b0;
    chk({tag, " job_ready after accept"}, job_ready, 0);
    chk({tag, " busy"}, busy, 1);
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!(avm_write && avm_address == 5'd22) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " run write seen"}, (avm_write && avm_address == 5'd22), 1);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int base, wc, held, budget, first_c;
    bit run_seen, stop_seen, irq_up, got_res, stable, rdy_low, done;
    logic [63:0] n0;
    logic [31:0] s0;
    logic t0;
    base = log_q.size();
    accept_job(v, tag);
    first_c = cyc;
    run_seen = 0; stop_seen = 0; irq_up = 0; got_res = 0; stable = 1; rdy_low = 1; done = 0;
    held = 0; wc = 0; budget = 3000; n0 = '1; s0 = '1; t0 = 1'bx;
    while (!done && budget > 0) begin
      budget--;
      if (res_ready) begin
        res_ready = 1'b0;
        done = 1;
        chk({tag, " job_ready after handshake"}, job_ready, 1);
        chk({tag, " res_valid after handshake"}, res_valid, 0);
      end else begin
        if (avm_write && avm_address == 5'd22) begin
          if (!run_seen) begin run_seen = 1; wc = 0; end
          else stop_seen = 1;
        end else if (run_seen) begin
          wc++;
          if (!irq_up && !stop_seen && v.irq_d >= 0 && wc - 1 == v.irq_d) begin
            avm_irq = 1'b1;
            irq_up = 1;
          end
        end
        if (avm_read && avm_address == 5'd22) avm_irq = 1'b0;
        if (res_valid) begin
          if (!got_res) begin
            got_res = 1; n0 = res_nonce; s0 = res_status; t0 = res_timeout;
          end else if (res_nonce !== n0 || res_status !== s0 || res_timeout !== t0) stable = 0;
          if (job_ready !== 1'b0) rdy_low = 0;
          if (held == v.rdy_d) res_ready = 1'b1;
          held++;
        end
      end
      if (!done) @(negedge clk);
    end
    avm_irq = 1'b0;
    res_ready = 1'b0;
    chk({tag, " job completed in bound"}, done, 1);
    chk({tag, " res_nonce"}, n0, v.e_nonce);
    chk({tag, " res_status"}, 64'(s0), 64'(v.e_status));
    chk({tag, " res_timeout"}, t0, v.e_to);
    chk({tag, " result stable"}, stable, 1);
    chk({tag, " job_ready low in RESULT"}, rdy_low, 1);
    chk({tag, " res_valid cycles"}, 64'(held), 64'(v.rdy_d + 1));
    build_exp(v);
    chk({tag, " access count"}, 64'(log_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      chk($sformatf("%s acc%0d op", tag, i), log_q[base + i].wr, exp_q[i].wr);
      chk($sformatf("%s acc%0d addr", tag, i), log_q[base + i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk($sformatf("%s acc%0d data", tag, i), log_q[base + i].data, exp_q[i].data);
      if (i < 19) chk($sformatf("%s acc%0d cycle", tag, i), 64'(log_q[base + i].c - first_c), 64'(i));
    end
  endtask

  initial begin
    int base;
    bit seen;
    vec_t v;
    tbl[0] = mk(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, '1,
                64'h0000_0001_0000_0000, 8'h06, 8'h80, 1'b0, 100, 64'hDEAD_BEEF_1234_5678, 32'h0000_0011,
                0, 64'hDEAD_BEEF_1234_5678, 32'h0000_0011, 1'b0, 32'h0680_0001);
    tbl[1] = mk({8{32'hA5A5_0F0F}}, {8{32'h0000_FFFF}}, 64'h1234_5678_9ABC_DEF0, 8'h06, 8'h80, 1'b0,
                -1, 64'h1111_2222_3333_4444, 32'hFFFF_FFFF, 2, 64'h0, 32'h0, 1'b1, 32'h0680_0001);
    tbl[2] = mk({8{32'h0102_0304}}, {8{32'h8000_0000}}, 64'h0, 8'h01, 8'h00, 1'b1,
                0, 64'h0000_0000_0000_0001, 32'h0000_0005, 1, 64'h1, 32'h5, 1'b0, 32'h0100_0003);
    tbl[3] = mk({8{32'hCAFE_F00D}}, {8{32'h0F0F_0F0F}}, 64'hFFFF_FFFF_FFFF_FFFF, 8'h1F, 8'h80, 1'b0,
                TO - 1, 64'h0BAD_F00D_0000_0042, 32'h0000_0102, 0, 64'h0BAD_F00D_0000_0042, 32'h102, 1'b0, 32'h1F80_0001);
    tbl[4] = mk({8{32'h5555_AAAA}}, {8{32'h7777_8888}}, 64'h0000_0000_0000_0100, 8'h06, 8'h80, 1'b0,
                TO, 64'h9999_9999_9999_9999, 32'h0000_0033, 0, 64'h0, 32'h0, 1'b1, 32'h0680_0001);
    tbl[5] = mk({8{32'h1357_9BDF}}, {8{32'h2468_ACE0}}, 64'h0000_0002_0000_0000, 8'h06, 8'h80, 1'b0,
                3, 64'hFEDC_BA98_7654_3210, 32'h0000_0001, 20, 64'hFEDC_BA98_7654_3210, 32'h1, 1'b0, 32'h0680_0001);

    rst = 1'b1; job_valid = 1'b0; job_header = '0; job_difficulty = '0; job_start_nonce = '0;
    job_pad_first = '0; job_pad_last = '0; job_test = 1'b0; abort = 1'b0; avm_irq = 1'b0;
    res_ready = 1'b0; sol_v = '0; stat_v = '0;
    repeat (3) @(negedge clk);
    chk("reset job_ready", job_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset strobes", {avm_read, avm_write}, 0);
    chk("reset address", avm_address, 0);
    chk("reset res_valid", res_valid, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_job(tbl[i], $sformatf("vec%0d", i));

    // Abort during the 5th load write: it completes, then stop write, then idle with no result.
    base = log_q.size();
    accept_job(tbl[0], "abortL");
    repeat (4) @(negedge clk);
    chk("abortL 5th write addr", {avm_write, avm_address}, {1'b1, 5'd8});
    chk("abortL 5th write data", avm_writedata, 32'h1011_1213);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortL stop write", {avm_write, avm_read, avm_address}, {1'b1, 1'b0, 5'd22});
    chk("abortL stop data", avm_writedata, 32'h0680_0000);
    @(negedge clk);
    chk("abortL job_ready", job_ready, 1);
    chk("abortL busy", busy, 0);
    seen = 0;
    repeat (5) begin
      if (res_valid) seen = 1;
      @(negedge clk);
    end
    chk("abortL no result", seen, 0);
    chk("abortL access count", 64'(log_q.size() - base), 64'd6);

    // Abort and irq together while waiting: abort wins, no reads.
    accept_job(tbl[0], "abortW");
    wait_run("abortW");
    repeat (4) @(negedge clk);
    abort = 1'b1; avm_irq = 1'b1;
    @(negedge clk);
    chk("abortW stop write", {avm_write, avm_read, avm_address}, {1'b1, 1'b0, 5'd22});
    chk("abortW stop data", avm_writedata, 32'h0680_0000);
    abort = 1'b0; avm_irq = 1'b0;
    @(negedge clk);
    chk("abortW idle", {job_ready, busy, res_valid}, 3'b100);

    // Reset pulse while waiting for the IRQ.
    accept_job(tbl[0], "rstW");
    wait_run("rstW");
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstW strobes", {avm_read, avm_write, avm_address}, 0);
    chk("rstW writedata", avm_writedata, 0);
    chk("rstW status flags", {job_ready, busy, res_valid, res_timeout}, 0);
    chk("rstW res_nonce", res_nonce, 0);
    chk("rstW res_status", res_status, 0);
    @(negedge clk);
    rst = 1'b0;
    run_job(tbl[2], "postrst");

    // Randomized jobs checked against the reference model.
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 8; w++) begin
        v.header = {v.header[223:0], 32'($urandom())};
        v.diff   = {v.diff[223:0], 32'($urandom())};
      end
      v.nonce = {32'($urandom()), 32'($urandom())};
      v.pf = 8'($urandom()); v.pl = 8'($urandom()); v.test = 1'($urandom());
      v.irq_d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 5));
      v.sol = {32'($urandom()), 32'($urandom())}; v.stat = 32'($urandom());
      v.rdy_d = int'($urandom_range(0, 5));
      run_job(model(v), $sformatf("rnd%0d", k));
    end

    chk("no simultaneous read and write", 64'(both_err), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
